// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the FP control/status path
package fp_pkg;
  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;
  localparam logic [1:0] CSR_RW = 2'b01;
  localparam logic [1:0] CSR_RS = 2'b10;
  localparam logic [1:0] CSR_RC = 2'b11;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;
  typedef enum logic {IDLE, RESP} csr_state_t;
endpackage

// File: rtl/fp_rm_resolve.sv
// fp_rm_resolve: picks the effective rounding mode and flags reserved encodings
module fp_rm_resolve
  import fp_pkg::*;
(
  input  logic [2:0] frm,
  input  logic [2:0] instr_rm,
  output logic [2:0] eff_rm,
  output logic       rm_illegal
);
  assign eff_rm     = (instr_rm == RM_DYN) ? frm : instr_rm;
  assign rm_illegal = eff_rm > RM_RMM;
endmodule

// File: rtl/fp_fcsr.sv
// fp_fcsr: sticky FP flags, frm storage, Zicsr access port and rm resolution
module fp_fcsr
  import fp_pkg::*;
#(
  parameter logic [2:0] RST_FRM = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_wen,
  output logic        csr_rvalid,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        fp_flag_valid,
  input  logic [4:0]  fp_flags,
  input  logic [2:0]  instr_rm,
  output logic [2:0]  eff_rm,
  output logic        rm_illegal,
  output logic [4:0]  fflags_o
);
  csr_state_t state, state_nxt;
  logic [4:0]  fflags, fflags_nxt;
  logic [2:0]  frm, frm_nxt;
  logic        legal, wr;
  logic [31:0] old_val, new_val;

  fp_rm_resolve u_rm (.frm(frm), .instr_rm(instr_rm), .eff_rm(eff_rm), .rm_illegal(rm_illegal));

  assign fflags_o   = fflags;
  assign csr_rvalid = state == RESP;

  // Next-state, CSR read/modify value and register updates
  always_comb begin
    state_nxt  = csr_valid ? RESP : IDLE;
    legal      = (csr_addr == CSR_FFLAGS || csr_addr == CSR_FRM || csr_addr == CSR_FCSR) && csr_op != 2'b00;
    old_val    = csr_addr == CSR_FFLAGS ? {27'b0, fflags} :
                 csr_addr == CSR_FRM    ? {29'b0, frm} : {24'b0, frm, fflags};
    new_val    = csr_op == CSR_RW ? csr_wdata :
                 csr_op == CSR_RS ? old_val | csr_wdata : old_val & ~csr_wdata;
    wr         = csr_valid && legal && csr_wen;
    fflags_nxt = ((wr && csr_addr != CSR_FRM) ? new_val[4:0] : fflags) | (fp_flag_valid ? fp_flags : 5'b0);
    frm_nxt    = !wr ? frm : csr_addr == CSR_FRM ? new_val[2:0] : csr_addr == CSR_FCSR ? new_val[7:5] : frm;
  end

  // State, CSR fields and response capture; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fflags      <= 5'b0;
      frm         <= RST_FRM;
      csr_rdata   <= 32'b0;
      csr_illegal <= 1'b0;
    end else begin
      state       <= state_nxt;
      fflags      <= fflags_nxt;
      frm         <= frm_nxt;
      csr_illegal <= csr_valid && !legal;
      if (csr_valid) csr_rdata <= legal ? old_val : 32'b0;
    end
  end
endmodule

// File: tb/tb_fp_fcsr.sv
// tb_fp_fcsr: directed self-checking bench for fp_fcsr
module tb_fp_fcsr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_valid = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = 32'h0;
  logic        csr_wen = 1'b1;
  logic        csr_rvalid, csr_illegal, rm_illegal;
  logic [31:0] csr_rdata;
  logic        fp_flag_valid = 1'b0;
  logic [4:0]  fp_flags = 5'b0;
  logic [2:0]  instr_rm = 3'b111;
  logic [2:0]  eff_rm;
  logic [4:0]  fflags_o;
  int tests = 0;
  int fails = 0;

  fp_fcsr #(.RST_FRM(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .fp_flag_valid(fp_flag_valid), .fp_flags(fp_flags),
    .instr_rm(instr_rm), .eff_rm(eff_rm), .rm_illegal(rm_illegal), .fflags_o(fflags_o)
  );

  always #5 clk = ~clk;

  // Issue one access at a negedge; returns at the next negedge with the response visible
  task automatic do_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           input logic wen, input logic fv, input logic [4:0] ff);
    @(negedge clk);
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd; csr_wen = wen;
    fp_flag_valid = fv; fp_flags = ff;
    @(negedge clk);
    csr_valid = 1'b0; csr_wen = 1'b1; fp_flag_valid = 1'b0; fp_flags = 5'b0;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (csr_rvalid !== 1'b0 || csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin fails++;
      $display("FAIL reset_out: got rvalid=%b ill=%b rdata=%h, want 0 0 0", csr_rvalid, csr_illegal, csr_rdata); end
    tests++; if (fflags_o !== 5'b0 || eff_rm !== 3'b000) begin fails++;
      $display("FAIL reset_state: got fflags=%b eff_rm=%b, want 00000 000", fflags_o, eff_rm); end
    @(negedge clk); rst_n = 1'b1;
    do_access(2'b01, 12'h003, 32'h0, 1'b0, 1'b0, 5'b0);
    tests++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin fails++;
      $display("FAIL read_fcsr: got rvalid=%b rdata=%h ill=%b, want 1 00000000 0", csr_rvalid, csr_rdata, csr_illegal); end
    @(negedge clk);
    tests++; if (csr_rvalid !== 1'b0) begin fails++;
      $display("FAIL rvalid_pulse: got %b want 0", csr_rvalid); end
  endtask

  task automatic test_flags;
    @(negedge clk); fp_flag_valid = 1'b1; fp_flags = 5'b10000;
    @(negedge clk); fp_flags = 5'b00001;
    @(negedge clk); fp_flag_valid = 1'b0; fp_flags = 5'b0;
    tests++; if (fflags_o !== 5'b10001) begin fails++;
      $display("FAIL flag_accum: got %b want 10001", fflags_o); end
    do_access(2'b10, 12'h001, 32'h0, 1'b0, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'h11 || csr_rvalid !== 1'b1) begin fails++;
      $display("FAIL read_fflags: got %h rvalid=%b want 00000011 1", csr_rdata, csr_rvalid); end
  endtask

  task automatic test_simultaneous;
    do_access(2'b01, 12'h003, 32'hFFFF_FFE5, 1'b1, 1'b1, 5'b00010);
    tests++; if (csr_rdata !== 32'h11) begin fails++;
      $display("FAIL simul_old: got %h want 00000011", csr_rdata); end
    tests++; if (fflags_o !== 5'b00111 || eff_rm !== 3'b111) begin fails++;
      $display("FAIL simul_state: got fflags=%b frm=%b want 00111 111", fflags_o, eff_rm); end
    do_access(2'b10, 12'h003, 32'h0, 1'b0, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'hE7) begin fails++;
      $display("FAIL simul_read: got %h want 000000e7", csr_rdata); end
  endtask

  task automatic test_set_clear;
    do_access(2'b01, 12'h001, 32'h1F, 1'b1, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'h07 || fflags_o !== 5'b11111) begin fails++;
      $display("FAIL rw_fflags: got rdata=%h fflags=%b want 00000007 11111", csr_rdata, fflags_o); end
    do_access(2'b11, 12'h001, 32'h10, 1'b1, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'h1F || fflags_o !== 5'b01111) begin fails++;
      $display("FAIL rc_fflags: got rdata=%h fflags=%b want 0000001f 01111", csr_rdata, fflags_o); end
    do_access(2'b10, 12'h001, 32'h10, 1'b0, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'h0F || fflags_o !== 5'b01111) begin fails++;
      $display("FAIL rs_nowen: got rdata=%h fflags=%b want 0000000f 01111", csr_rdata, fflags_o); end
  endtask

  task automatic test_rm;
    do_access(2'b01, 12'h002, 32'h1, 1'b1, 1'b0, 5'b0);
    instr_rm = 3'b111; #1;
    tests++; if (csr_rdata !== 32'h7 || eff_rm !== 3'b001 || rm_illegal !== 1'b0) begin fails++;
      $display("FAIL rm_dyn: got rdata=%h eff=%b ill=%b want 00000007 001 0", csr_rdata, eff_rm, rm_illegal); end
    do_access(2'b01, 12'h002, 32'h6, 1'b1, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'h1 || eff_rm !== 3'b110 || rm_illegal !== 1'b1) begin fails++;
      $display("FAIL rm_dyn_bad: got rdata=%h eff=%b ill=%b want 00000001 110 1", csr_rdata, eff_rm, rm_illegal); end
    instr_rm = 3'b101; #1;
    tests++; if (eff_rm !== 3'b101 || rm_illegal !== 1'b1) begin fails++;
      $display("FAIL rm_static_bad: got eff=%b ill=%b want 101 1", eff_rm, rm_illegal); end
    instr_rm = 3'b100; #1;
    tests++; if (eff_rm !== 3'b100 || rm_illegal !== 1'b0) begin fails++;
      $display("FAIL rm_static_ok: got eff=%b ill=%b want 100 0", eff_rm, rm_illegal); end
    instr_rm = 3'b111;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    csr_valid = 1'b1; csr_op = 2'b10; csr_addr = 12'h002; csr_wdata = 32'h0; csr_wen = 1'b0;
    @(negedge clk);
    tests++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h6) begin fails++;
      $display("FAIL b2b_first: got rvalid=%b rdata=%h want 1 00000006", csr_rvalid, csr_rdata); end
    csr_op = 2'b01; csr_addr = 12'h001; csr_wdata = 32'h3; csr_wen = 1'b1;
    @(negedge clk);
    csr_valid = 1'b0;
    tests++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0F || fflags_o !== 5'b00011) begin fails++;
      $display("FAIL b2b_second: got rvalid=%b rdata=%h fflags=%b want 1 0000000f 00011", csr_rvalid, csr_rdata, fflags_o); end
    @(negedge clk);
    tests++; if (csr_rvalid !== 1'b0) begin fails++;
      $display("FAIL b2b_idle: got rvalid=%b want 0", csr_rvalid); end
  endtask

  task automatic test_illegal_reset;
    do_access(2'b01, 12'h004, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'b0);
    tests++; if (csr_rvalid !== 1'b1 || csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin fails++;
      $display("FAIL bad_addr: got rvalid=%b ill=%b rdata=%h want 1 1 00000000", csr_rvalid, csr_illegal, csr_rdata); end
    tests++; if (fflags_o !== 5'b00011 || eff_rm !== 3'b110) begin fails++;
      $display("FAIL bad_addr_state: got fflags=%b frm=%b want 00011 110", fflags_o, eff_rm); end
    do_access(2'b00, 12'h001, 32'h0, 1'b1, 1'b0, 5'b0);
    tests++; if (csr_illegal !== 1'b1 || fflags_o !== 5'b00011) begin fails++;
      $display("FAIL bad_op: got ill=%b fflags=%b want 1 00011", csr_illegal, fflags_o); end
    @(negedge clk);
    tests++; if (csr_illegal !== 1'b0) begin fails++;
      $display("FAIL ill_pulse: got %b want 0", csr_illegal); end
    do_access(2'b10, 12'h003, 32'h0, 1'b0, 1'b0, 5'b0);
    tests++; if (csr_rdata !== 32'hC3) begin fails++;
      $display("FAIL pre_reset_read: got %h want 000000c3", csr_rdata); end
    rst_n = 1'b0; #1;
    tests++; if (csr_rvalid !== 1'b0 || csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin fails++;
      $display("FAIL midreset_out: got rvalid=%b ill=%b rdata=%h want 0 0 0", csr_rvalid, csr_illegal, csr_rdata); end
    tests++; if (fflags_o !== 5'b0 || eff_rm !== 3'b000) begin fails++;
      $display("FAIL midreset_state: got fflags=%b frm=%b want 00000 000", fflags_o, eff_rm); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests++; if (csr_rvalid !== 1'b0 || fflags_o !== 5'b0) begin fails++;
      $display("FAIL post_reset: got rvalid=%b fflags=%b want 0 00000", csr_rvalid, fflags_o); end
  endtask

  initial begin
    test_reset;
    test_flags;
    test_simultaneous;
    test_set_clear;
    test_rm;
    test_back_to_back;
    test_illegal_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
